pmem_responder: RTL
===================

# pmem_responder

Synthesizable physical-memory responder that serves the cache-side pmem protocol driven by the L2 cache controller. It accepts one 128-bit cacheline read or write at a time, models a fixed access latency with a countdown counter, and completes each transaction with a single-cycle pmem_resp. It sits below L2 in the memory hierarchy and replaces the behavioural memory model in synthesized builds and FPGA bring-up.

## Interface
- LATENCY, 4, busy cycles between request acceptance and the access edge; legal range 1..255
- IDX_W, 6, line-index width; the array holds 2**IDX_W cachelines
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- pmem_read  input  1  read request, held by the initiator until pmem_resp
- pmem_write  input  1  write request, held by the initiator until pmem_resp
- pmem_address  input  16  byte address (lc3b_word); bits [3:0] ignored; line index = bits [IDX_W+3:4]
- pmem_wdata  input  128  write line (lc3b_cacheline)
- pmem_resp  output  1  one-cycle completion pulse
- pmem_rdata  output  128  read line, valid while pmem_resp=1
- proto_err  output  1  sticky protocol-violation flag
- rd_count  output  16  completed reads, wraps at 16'hFFFF->0
- wr_count  output  16  completed writes, wraps at 16'hFFFF->0

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: if pmem_read^pmem_write, latch op, load cnt=LATENCY-1, go BUSY. If both are high, stay IDLE and set proto_err. If neither, stay.
- BUSY, cnt!=0: decrement cnt. If the latched op's request line drops, or the other request line rises, abort to IDLE with no array update and no count change; set proto_err.
- BUSY, cnt==0, request still valid: on this edge sample pmem_address (and pmem_wdata for a write). A read registers array[idx] into pmem_rdata; a write stores pmem_wdata to array[idx]. Increment rd_count or wr_count. Go RESP.
- RESP: pmem_resp=1 for exactly this cycle, then unconditionally IDLE. Any request visible in the following IDLE cycle is a new transaction.
- Address/data are sampled late, at the access edge, not at acceptance. This absorbs the one-cycle registered-address skew of the L2 initiator.
- pmem_rdata holds its last read value until the next read completes. Writes do not change pmem_rdata.
- proto_err clears only on reset.
- Array contents are not reset.

## Timing
- Request first high in cycle 0 (IDLE) -> BUSY cycles 1..LATENCY -> pmem_resp high in cycle LATENCY+1 -> IDLE in cycle LATENCY+2.
- Throughput: one transaction per LATENCY+2 cycles. L2 write_back followed by fetch_cline therefore costs 2*(LATENCY+2) cycles.
- Read-after-write to the same line returns the new data: the write completes before the read is accepted.
- Reset values: state=IDLE, cnt=0, pmem_resp=0, pmem_rdata=0, proto_err=0, rd_count=0, wr_count=0.
- Reset asserted mid-BUSY or in RESP: return to IDLE immediately (asynchronously); pmem_resp drops the same instant. An aborted write leaves the array untouched.
- Counter overflow wraps silently.

## Structure
- The pmem line width (128) and address type come from lc3b_types (lc3b_cacheline, lc3b_word). Add a pmem_resp_state_t enum to lc3b_types so benches can probe the state.
- One sub-module: pmem_line_array, a 2**IDX_W x 128 synchronous array with a single port (we, idx, wdata, registered rdata). The FSM, counter and statistics stay in pmem_responder.

## Test plan
- Reset, then write 128'h0123..CDEF to address 16'h0040 with LATENCY=4 -> pmem_resp high exactly in cycle 5 for one cycle; wr_count=1.
- Read 16'h004A -> pmem_resp in cycle 5; pmem_rdata=128'h0123..CDEF (offset bits ignored); rd_count=1.
- L2-style back-to-back sequence: write line A to 16'h0100, then immediately read 16'h0200 with the address changing one cycle after pmem_read rises -> correct line returned; two pmem_resp pulses spaced 6 cycles apart.
- Assert pmem_read and pmem_write together -> no pmem_resp, proto_err=1, counts unchanged.
- Drop pmem_write in BUSY cycle 2 -> no pmem_resp; array line unchanged on later read; proto_err=1.
- Deassert rst_n in BUSY, release, issue a read -> pmem_resp=0 during reset, all outputs at reset values, next read completes normally in LATENCY+1 cycles.

Source files
------------

// File: rtl/pmem_responder_pkg.sv
// Shared pmem types: cacheline and word widths plus the responder state encoding.
`timescale 1ns/1ps
package lc3b_types;

   typedef logic [127:0] lc3b_cacheline;
   typedef logic [15:0]  lc3b_word;

   typedef enum logic [1:0] {
      PMEM_IDLE = 2'd0,
      PMEM_BUSY = 2'd1,
      PMEM_RESP = 2'd2
   } pmem_resp_state_t;

endpackage

// File: rtl/pmem_responder_line_array.sv
// Single-port cacheline array: synchronous write, registered read that holds
// its value until the next read. Storage is not reset; the read register is.
`timescale 1ns/1ps
module pmem_line_array #(
   parameter int IDX_W = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               we,
   input  logic               re,
   input  logic [IDX_W-1:0]   idx,
   input  logic [127:0]       wdata,
   output logic [127:0]       rdata
);

   logic [127:0] mem [2**IDX_W];

   // Line storage update on write strobe
   always_ff @(posedge clk) begin
      if (we) mem[idx] <= wdata;
   end

   // Read register, loaded only when a read completes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rdata <= '0;
      else if (re) rdata <= mem[idx];
   end

endmodule

// File: rtl/pmem_responder.sv
// Fixed-latency physical-memory responder for the L2 pmem port. One line
// transaction at a time; address/data are sampled at the access edge, not at
// acceptance, so a one-cycle-late address from the initiator is tolerated.
`timescale 1ns/1ps
module pmem_responder
   import lc3b_types::*;
#(
   parameter int LATENCY = 4,
   parameter int IDX_W   = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pmem_read,
   input  logic          pmem_write,
   input  logic [15:0]   pmem_address,
   input  logic [127:0]  pmem_wdata,
   output logic          pmem_resp,
   output logic [127:0]  pmem_rdata,
   output logic          proto_err,
   output logic [15:0]   rd_count,
   output logic [15:0]   wr_count
);

   localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

   pmem_resp_state_t state_q;
   logic             op_write;
   logic [7:0]       cnt;
   logic             req_ok;
   logic             access;
   logic             arr_we;
   logic             arr_re;
   logic [IDX_W-1:0] idx;
   logic             unused_addr_bits;

   // Request validity against the latched op, and the access-edge strobes
   always_comb begin
      req_ok = op_write ? (pmem_write && !pmem_read) : (pmem_read && !pmem_write);
      access = (state_q == PMEM_BUSY) && (cnt == '0) && req_ok;
      arr_we = access && op_write;
      arr_re = access && !op_write;
   end

   assign idx              = pmem_address[IDX_W+3:4];
   assign unused_addr_bits = ^{pmem_address[15:IDX_W+4], pmem_address[3:0]};

   // Transaction FSM with latency countdown, response pulse and statistics
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= PMEM_IDLE;
         op_write  <= 1'b0;
         cnt       <= '0;
         pmem_resp <= 1'b0;
         proto_err <= 1'b0;
         rd_count  <= '0;
         wr_count  <= '0;
      end else begin
         pmem_resp <= 1'b0;
         case (state_q)
            PMEM_IDLE: begin
               if (pmem_read ^ pmem_write) begin
                  op_write <= pmem_write;
                  cnt      <= LAT_M1;
                  state_q  <= PMEM_BUSY;
               end else if (pmem_read && pmem_write) begin
                  proto_err <= 1'b1;
               end
            end
            PMEM_BUSY: begin
               if (!req_ok) begin
                  proto_err <= 1'b1;
                  cnt       <= '0;
                  state_q   <= PMEM_IDLE;
               end else if (cnt != '0) begin
                  cnt <= cnt - 8'd1;
               end else begin
                  if (op_write) wr_count <= wr_count + 16'd1;
                  else          rd_count <= rd_count + 16'd1;
                  pmem_resp <= 1'b1;
                  state_q   <= PMEM_RESP;
               end
            end
            PMEM_RESP: state_q <= PMEM_IDLE;
            default:   state_q <= PMEM_IDLE;
         endcase
      end
   end

   pmem_line_array #(.IDX_W(IDX_W)) u_array (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (arr_we),
      .re    (arr_re),
      .idx   (idx),
      .wdata (pmem_wdata),
      .rdata (pmem_rdata)
   );

endmodule
